// File: rtl/traffic_light_controller_param.sv
// Two-approach NS/EW intersection controller with all-red clearance and night flash.
// Optional pedestrian walk phase is built only when PED_WALK_EN is defined.
module traffic_light_controller_param #(
  parameter int TW       = 4,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int FLASH_T  = 3,
  parameter int WALK_T   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ew_car,
  input  logic          flash,
`ifdef PED_WALK_EN
  input  logic          ped_req,
  output logic          walk,
`endif
  output logic          ns_red,
  output logic          ns_yellow,
  output logic          ns_green,
  output logic          ew_red,
  output logic          ew_yellow,
  output logic          ew_green,
  output logic [2:0]    phase,
  output logic [TW-1:0] timer
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    FLASH     = 3'd6,
    PED_WALK  = 3'd7
  } state_e;

  localparam logic [TW-1:0] GRN_L = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] YEL_L = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_L  = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] FL_L  = TW'(FLASH_T - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          blink_q, blink_d;

`ifdef PED_WALK_EN
  localparam logic [TW-1:0] WLK_L = TW'(WALK_T - 1);
  logic ped_q, ped_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ALL_RED_2;
      timer_q <= '0;
      blink_q <= 1'b1;
`ifdef PED_WALK_EN
      ped_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
`ifdef PED_WALK_EN
      ped_q   <= ped_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    blink_d = blink_q;
`ifdef PED_WALK_EN
    ped_d   = ped_q | ped_req;
`endif
    if (flash && state_q != FLASH) begin
      state_d = FLASH;
      timer_d = '0;
      blink_d = 1'b1;
`ifdef PED_WALK_EN
      ped_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        NS_GREEN: begin
          // Green rests here, pinned at its minimum, until EW demand shows up
          if (timer_q >= GRN_L) begin
            if (ew_car) begin
              state_d = NS_YELLOW;
              timer_d = '0;
            end else begin
              timer_d = GRN_L;
            end
          end
        end
        NS_YELLOW: begin
          if (timer_q == YEL_L) begin
            state_d = ALL_RED_1;
            timer_d = '0;
          end
        end
        ALL_RED_1: begin
          if (timer_q == AR_L) begin
            state_d = EW_GREEN;
            timer_d = '0;
          end
        end
        EW_GREEN: begin
          if (timer_q == GRN_L) begin
            state_d = EW_YELLOW;
            timer_d = '0;
          end
        end
        EW_YELLOW: begin
          if (timer_q == YEL_L) begin
            state_d = ALL_RED_2;
            timer_d = '0;
          end
        end
        ALL_RED_2: begin
          if (timer_q == AR_L) begin
            state_d = NS_GREEN;
            timer_d = '0;
`ifdef PED_WALK_EN
            if (ped_q || ped_req) begin
              state_d = PED_WALK;
              ped_d   = 1'b0;
            end
`endif
          end
        end
        FLASH: begin
          if (!flash) begin
            state_d = ALL_RED_2;
            timer_d = '0;
          end else if (timer_q == FL_L) begin
            timer_d = '0;
            blink_d = ~blink_q;
          end
        end
`ifdef PED_WALK_EN
        PED_WALK: begin
          if (timer_q == WLK_L) begin
            state_d = NS_GREEN;
            timer_d = '0;
          end
        end
`endif
        default: begin
          state_d = ALL_RED_2;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ns_red    = 1'b0;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b0;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
`ifdef PED_WALK_EN
    walk      = 1'b0;
`endif
    case (state_q)
      NS_GREEN: begin
        ns_green = 1'b1;
        ew_red   = 1'b1;
      end
      NS_YELLOW: begin
        ns_yellow = 1'b1;
        ew_red    = 1'b1;
      end
      EW_GREEN: begin
        ns_red   = 1'b1;
        ew_green = 1'b1;
      end
      EW_YELLOW: begin
        ns_red    = 1'b1;
        ew_yellow = 1'b1;
      end
      FLASH: begin
        ns_yellow = blink_q;
        ew_red    = blink_q;
      end
`ifdef PED_WALK_EN
      PED_WALK: begin
        ns_red = 1'b1;
        ew_red = 1'b1;
        walk   = 1'b1;
      end
`endif
      default: begin
        ns_red = 1'b1;
        ew_red = 1'b1;
      end
    endcase
  end

  assign phase = state_q;
  assign timer = timer_q;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Bench for traffic_light_controller_param: phase-table model checked every cycle
// plus hand-computed sequences for sequence, rest, flash and reset cases.
module tb_traffic_light_controller_param;

  localparam int TW = 4;
  localparam int G  = 5;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int FL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ew_car = 1'b1;
  logic          flash = 1'b0;
  logic          ns_red, ns_yellow, ns_green;
  logic          ew_red, ew_yellow, ew_green;
  logic [2:0]    phase;
  logic [TW-1:0] timer;
`ifdef PED_WALK_EN
  logic          ped_req = 1'b0;
  logic          walk;
`endif
  logic [5:0]    lv;

  assign lv = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

  traffic_light_controller_param #(
    .TW(TW), .GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(AR), .FLASH_T(FL), .WALK_T(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ew_car    (ew_car),
    .flash     (flash),
`ifdef PED_WALK_EN
    .ped_req   (ped_req),
    .walk      (walk),
`endif
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .phase     (phase),
    .timer     (timer)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the normal cycle is phases 0..5 in order, each with a duration;
  // NS green may overstay, holding its count at the minimum.
  function automatic int dur(input int p);
    case (p)
      0, 3:    return G;
      1, 4:    return Y;
      default: return AR;
    endcase
  endfunction

  function automatic logic [5:0] lamps(input int p, input bit b);
    logic nr, ny, ng, er, ey, eg;
    ng = (p == 0);
    ny = (p == 1) || (p == 6 && b);
    nr = (p >= 2 && p <= 5);
    eg = (p == 3);
    ey = (p == 4);
    er = (p == 0 || p == 1 || p == 2 || p == 5) || (p == 6 && b);
    return {nr, ny, ng, er, ey, eg};
  endfunction

  int m_ph = 5;
  int m_t  = 0;
  bit m_b  = 1'b1;

  always @(posedge clk) begin : model
    int p, t;
    bit b;
    p = m_ph;
    t = m_t;
    b = m_b;
    if (reset) begin
      p = 5; t = 0; b = 1'b1;
    end else if (flash && p != 6) begin
      p = 6; t = 0; b = 1'b1;
    end else if (p == 6) begin
      if (!flash) begin
        p = 5; t = 0;
      end else if (t == FL - 1) begin
        t = 0; b = !b;
      end else begin
        t = t + 1;
      end
    end else if (t >= dur(p) - 1 && (p != 0 || ew_car)) begin
      p = (p + 1) % 6;
      t = 0;
    end else begin
      t = (t + 1 < dur(p)) ? t + 1 : dur(p) - 1;
    end
    m_ph <= p;
    m_t  <= t;
    m_b  <= b;
  end

  bit chk_en  = 1'b0;
  bit rnd_en  = 1'b0;
  int prev_ph = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_phase", int'(phase), m_ph);
      chk("model_timer", int'(timer), m_t);
      chk("model_lamps", int'(lv), int'(lamps(m_ph, m_b)));
      chk("no_conflict",
          int'((ns_green | ns_yellow) & (ew_green | ew_yellow)), 0);
      if (phase != 3'd6) begin
        chk("one_lamp_ns", $countones({ns_red, ns_yellow, ns_green}), 1);
        chk("one_lamp_ew", $countones({ew_red, ew_yellow, ew_green}), 1);
      end
      if (rnd_en && (phase == 3'd2 || phase == 3'd5))
        chk("allred_len", int'(prev_ph == int'(phase)), 0);
      prev_ph = int'(phase);
    end
  end

  int SEQ_P[16] = '{5, 0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4};
  int SEQ_T[16] = '{0, 0, 1, 2, 3, 4, 0, 1, 0, 0, 1, 2, 3, 4, 0, 1};
  int FLP[7]    = '{1, 1, 1, 0, 0, 0, 1};

  task automatic check_seq(input int n);
    for (int i = 0; i < n; i++) begin
      chk("seq_phase", int'(phase), SEQ_P[i % 16]);
      chk("seq_timer", int'(timer), SEQ_T[i % 16]);
      @(negedge clk);
    end
  endtask

  task automatic wait_until(input int p, input int t);
    int k = 0;
    while (!(int'(phase) == p && int'(timer) == t) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_bound", int'(k < 200), 1);
  endtask

  initial begin
    reset  = 1'b1;
    ew_car = 1'b1;
    flash  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_phase", int'(phase), 5);
    chk("rst_timer", int'(timer), 0);
    chk("rst_lamps", int'(lv), int'(6'b100100));
    reset = 1'b0;

    check_seq(32);

    ew_car = 1'b0;
    wait_until(0, 0);
    for (int i = 0; i < 30; i++) begin
      chk("rest_phase", int'(phase), 0);
      chk("rest_timer", int'(timer), (i < 4) ? i : 4);
      @(negedge clk);
    end
    chk("rest_hold", int'(phase), 0);
    ew_car = 1'b1;
    @(negedge clk);
    chk("rest_exit_phase", int'(phase), 1);
    chk("rest_exit_lamps", int'(lv), int'(6'b010100));

    wait_until(3, 2);
    flash = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      chk("flash_phase", int'(phase), 6);
      chk("flash_ns_yellow", int'(ns_yellow), FLP[i]);
      chk("flash_ew_red", int'(ew_red), FLP[i]);
      chk("flash_others",
          int'({ns_red, ns_green, ew_yellow, ew_green}), 0);
      if (i < 6) @(negedge clk);
    end
    flash = 1'b0;
    @(negedge clk);
    chk("unflash_allred", int'(phase), 5);
    @(negedge clk);
    chk("unflash_nsgreen", int'(phase), 0);

    wait_until(1, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_phase", int'(phase), 5);
    chk("rst2_timer", int'(timer), 0);
    chk("rst2_lamps", int'(lv), int'(6'b100100));
    reset = 1'b0;
    check_seq(16);

    rnd_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      ew_car = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) flash = ~flash;
      @(negedge clk);
    end
    rnd_en = 1'b0;
    flash  = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
